// File: rtl/eth_rx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_stream_arbiter
// Brief    : Packet-granular two-input round-robin AXI-Stream arbiter feeding
//            a single packet filter. Holds the grant for a whole packet,
//            truncates over-long packets (forced tlast) and drains the rest.
//            Exports grant state and per-source packet/truncation counters.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_stream_arbiter #(
    parameter int STREAM_DATA_WIDTH = 32,
    parameter int MAX_BEATS         = 400,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                           clk_i,
    input  logic                           s_rst_n_i,

    input  logic [STREAM_DATA_WIDTH-1:0]   s0_axis_tdata_i,
    input  logic [STREAM_DATA_WIDTH/8-1:0] s0_axis_tkeep_i,
    input  logic                           s0_axis_tvalid_i,
    input  logic                           s0_axis_tlast_i,
    output logic                           s0_axis_tready_o,

    input  logic [STREAM_DATA_WIDTH-1:0]   s1_axis_tdata_i,
    input  logic [STREAM_DATA_WIDTH/8-1:0] s1_axis_tkeep_i,
    input  logic                           s1_axis_tvalid_i,
    input  logic                           s1_axis_tlast_i,
    output logic                           s1_axis_tready_o,

    output logic [STREAM_DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic [STREAM_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
    output logic                           m_axis_tvalid_o,
    output logic                           m_axis_tlast_o,
    input  logic                           m_axis_tready_i,

    output logic [1:0]                     grant_o,
    output logic                           busy_o,
    output logic [CNT_WIDTH-1:0]           pkt_cnt0_o,
    output logic [CNT_WIDTH-1:0]           pkt_cnt1_o,
    output logic [CNT_WIDTH-1:0]           trunc_cnt_o
);

    localparam int                   c_keep_w    = STREAM_DATA_WIDTH / 8;
    // Beat counter is 16 bits wide: MAX_BEATS is bounded to 65535.
    localparam logic [15:0]          c_last_beat = 16'(MAX_BEATS - 1);
    localparam logic [15:0]          c_beat_one  = 16'd1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_sel;
    logic                    r_last_sel;
    logic [15:0]             r_beat_cnt;
    logic [CNT_WIDTH-1:0]    r_pkt_cnt0;
    logic [CNT_WIDTH-1:0]    r_pkt_cnt1;
    logic [CNT_WIDTH-1:0]    r_trunc_cnt;

    logic [STREAM_DATA_WIDTH-1:0] w_src_data;
    logic [c_keep_w-1:0]          w_src_keep;
    logic                         w_src_valid;
    logic                         w_src_last;
    logic                         w_in_busy;
    logic                         w_in_drain;
    logic                         w_sel_ready;
    logic                         w_accept;
    logic                         w_at_limit;
    logic                         w_any_req;
    logic                         w_pick;

    // Select the currently granted source (data path is a pure mux, no register)
    always_comb begin
        w_src_data  = s0_axis_tdata_i;
        w_src_keep  = s0_axis_tkeep_i;
        w_src_valid = s0_axis_tvalid_i;
        w_src_last  = s0_axis_tlast_i;
        if (r_sel) begin
            w_src_data  = s1_axis_tdata_i;
            w_src_keep  = s1_axis_tkeep_i;
            w_src_valid = s1_axis_tvalid_i;
            w_src_last  = s1_axis_tlast_i;
        end
    end

    assign w_in_busy  = (r_state == ST_BUSY);
    assign w_in_drain = (r_state == ST_DRAIN);

    // In DRAIN the granted source is always accepted so its tail is discarded.
    assign w_sel_ready = w_in_drain | (w_in_busy & m_axis_tready_i);
    assign w_accept    = w_in_busy & w_src_valid & m_axis_tready_i;
    assign w_at_limit  = (r_beat_cnt == c_last_beat);

    // Lone requester wins outright; a tie goes to the source not served last.
    assign w_any_req = s0_axis_tvalid_i | s1_axis_tvalid_i;
    assign w_pick    = (s0_axis_tvalid_i & s1_axis_tvalid_i) ? ~r_last_sel : s1_axis_tvalid_i;

    assign s0_axis_tready_o = w_sel_ready & ~r_sel;
    assign s1_axis_tready_o = w_sel_ready &  r_sel;

    assign m_axis_tdata_o  = w_in_busy ? w_src_data : '0;
    assign m_axis_tkeep_o  = w_in_busy ? w_src_keep : '0;
    assign m_axis_tvalid_o = w_in_busy & w_src_valid;
    // tlast is forced on the final permitted beat of an over-long packet.
    assign m_axis_tlast_o  = w_in_busy & w_src_valid & (w_src_last | w_at_limit);

    assign grant_o     = (r_state == ST_IDLE) ? 2'b00 : (r_sel ? 2'b10 : 2'b01);
    assign busy_o      = (r_state != ST_IDLE);
    assign pkt_cnt0_o  = r_pkt_cnt0;
    assign pkt_cnt1_o  = r_pkt_cnt1;
    assign trunc_cnt_o = r_trunc_cnt;

    // Arbitration state machine with beat counting and status counters
    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            r_state     <= ST_IDLE;
            r_sel       <= 1'b0;
            r_last_sel  <= 1'b1;
            r_beat_cnt  <= '0;
            r_pkt_cnt0  <= '0;
            r_pkt_cnt1  <= '0;
            r_trunc_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_sel      <= w_pick;
                        r_last_sel <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + c_beat_one;
                        if (w_src_last || w_at_limit) begin
                            if (r_sel) begin
                                r_pkt_cnt1 <= r_pkt_cnt1 + c_cnt_one;
                            end else begin
                                r_pkt_cnt0 <= r_pkt_cnt0 + c_cnt_one;
                            end
                        end
                        if (w_src_last) begin
                            r_state <= ST_IDLE;
                        end else if (w_at_limit) begin
                            r_trunc_cnt <= r_trunc_cnt + c_cnt_one;
                            r_state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_src_valid && w_src_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_stream_arbiter
// Brief    : Randomised self-checking bench for eth_rx_stream_arbiter. Two
//            packet sources and a throttling sink; a packet-level reference
//            model predicts grants, forwarded beats, truncation and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_stream_arbiter;

    localparam int DW   = 32;
    localparam int KW   = DW / 8;
    localparam int MAXB = 8;
    localparam int CW   = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy0;
    logic          rdy1;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [1:0]    grant;
    logic          busy;
    logic [CW-1:0] pc0;
    logic [CW-1:0] pc1;
    logic [CW-1:0] tc;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit start  = 0;
    bit stop   = 0;
    bit gap_en = 0;
    int tready_mode = 0;

    always #5 clk = ~clk;

    // Packet sources: each owns its stream signals and its expected-beat queue
    for (genvar g = 0; g < 2; g++) begin : g_src
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          v;
        logic          l;
        logic          rdy;
        bit            done;
        beat_t         q[$];

        assign rdy = (g == 0) ? rdy0 : rdy1;

        initial begin
            beat_t pkt[$];
            beat_t b;
            int    len;
            int    wc;
            bit    acc;
            bit    abort;
            d = '0; k = '0; v = 1'b0; l = 1'b0; done = 1'b0; abort = 1'b0;
            wait (start);
            while (!stop && !abort) begin
                len = ($urandom_range(0, 3) == 0) ? MAXB : int'($urandom_range(1, 13));
                pkt.delete();
                for (int i = 0; i < len; i++) begin
                    b.data = $urandom;
                    b.keep = KW'($urandom_range(1, 15));
                    b.last = (i == len - 1);
                    pkt.push_back(b);
                    q.push_back(b);
                end
                for (int i = 0; i < len && !abort; i++) begin
                    while (gap_en && $urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    d = pkt[i].data; k = pkt[i].keep; l = pkt[i].last; v = 1'b1;
                    wc = 0;
                    do begin
                        @(negedge clk);
                        acc = v && rdy && rst_n;
                        @(posedge clk); #1;
                        wc++;
                    end while (!acc && wc < 2000);
                    v = 1'b0;
                    if (!acc) begin
                        checks++; errors++;
                        $display("FAIL src%0d_handshake_timeout: beat %0d not accepted in %0d cycles, required acceptance", g, i, wc);
                        abort = 1'b1;
                    end
                end
                if (gap_en) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                    end
                end
            end
            done = 1'b1;
        end
    end

    eth_rx_stream_arbiter #(
        .STREAM_DATA_WIDTH (DW),
        .MAX_BEATS         (MAXB),
        .CNT_WIDTH         (CW)
    ) u_dut (
        .clk_i            (clk),
        .s_rst_n_i        (rst_n),
        .s0_axis_tdata_i  (g_src[0].d),
        .s0_axis_tkeep_i  (g_src[0].k),
        .s0_axis_tvalid_i (g_src[0].v),
        .s0_axis_tlast_i  (g_src[0].l),
        .s0_axis_tready_o (rdy0),
        .s1_axis_tdata_i  (g_src[1].d),
        .s1_axis_tkeep_i  (g_src[1].k),
        .s1_axis_tvalid_i (g_src[1].v),
        .s1_axis_tlast_i  (g_src[1].l),
        .s1_axis_tready_o (rdy1),
        .m_axis_tdata_o   (m_tdata),
        .m_axis_tkeep_o   (m_tkeep),
        .m_axis_tvalid_o  (m_tvalid),
        .m_axis_tlast_o   (m_tlast),
        .m_axis_tready_i  (m_tready),
        .grant_o          (grant),
        .busy_o           (busy),
        .pkt_cnt0_o       (pc0),
        .pkt_cnt1_o       (pc1),
        .trunc_cnt_o      (tc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_beat(input bit n, output beat_t b, output bit ok);
        ok = 1'b1;
        b  = '0;
        if (n == 1'b0) begin
            if (g_src[0].q.size() == 0) ok = 1'b0;
            else b = g_src[0].q.pop_front();
        end else begin
            if (g_src[1].q.size() == 0) ok = 1'b0;
            else b = g_src[1].q.pop_front();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL queue_underflow: src%0d beat consumed, expected none pending", n);
        end
    endtask

    // Sink readiness: always ready, random, or strictly alternating
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                1:       m_tready = 1'($urandom_range(0, 1));
                2:       m_tready = ~m_tready;
                default: m_tready = 1'b1;
            endcase
        end
    end

    // Reference model state: packet-level view of the arbiter
    bit            mb    = 0;
    bit            md    = 0;
    bit            ms    = 0;
    bit            ml    = 1;
    int            mbeat = 0;
    logic [CW-1:0] e0    = '0;
    logic [CW-1:0] e1    = '0;
    logic [CW-1:0] et    = '0;

    // Monitor: compare the DUT against the model, then advance the model
    always @(negedge clk) begin
        logic  sv;
        logic  sl;
        logic  rs;
        logic  ro;
        beat_t b;
        bit    ok;
        logic  exp_last;
        if (chk_en) begin
            chk("grant", 32'(grant), mb ? (ms ? 32'd2 : 32'd1) : 32'd0);
            chk("busy", 32'(busy), 32'(mb));
            chk("pkt_cnt0", 32'(pc0), 32'(e0));
            chk("pkt_cnt1", 32'(pc1), 32'(e1));
            chk("trunc_cnt", 32'(tc), 32'(et));
            sv = ms ? g_src[1].v : g_src[0].v;
            sl = ms ? g_src[1].l : g_src[0].l;
            rs = ms ? rdy1 : rdy0;
            ro = ms ? rdy0 : rdy1;
            if (!mb) begin
                chk("idle_tvalid", 32'(m_tvalid), 32'd0);
                chk("idle_tlast", 32'(m_tlast), 32'd0);
                chk("idle_tdata", m_tdata, 32'd0);
                chk("idle_tkeep", 32'(m_tkeep), 32'd0);
                chk("idle_tready", {30'd0, rdy1, rdy0}, 32'd0);
                if (rst_n && (g_src[0].v || g_src[1].v)) begin
                    ms    = (g_src[0].v && g_src[1].v) ? !ml : g_src[1].v;
                    ml    = ms;
                    mb    = 1;
                    md    = 0;
                    mbeat = 0;
                end
            end else if (!md) begin
                chk("tvalid", 32'(m_tvalid), 32'(sv));
                chk("tready_sel", 32'(rs), 32'(m_tready));
                chk("tready_other", 32'(ro), 32'd0);
                if (sv && m_tready && rst_n) begin
                    pop_beat(ms, b, ok);
                    if (ok) begin
                        mbeat++;
                        exp_last = b.last || (mbeat == MAXB);
                        chk("tdata", m_tdata, b.data);
                        chk("tkeep", 32'(m_tkeep), 32'(b.keep));
                        chk("tlast", 32'(m_tlast), 32'(exp_last));
                        if (exp_last) begin
                            if (ms) e1 = e1 + 1'b1;
                            else    e0 = e0 + 1'b1;
                            mb = 0;
                            if (!b.last) begin
                                et = et + 1'b1;
                                mb = 1;
                                md = 1;
                            end
                        end
                    end
                end
            end else begin
                chk("drain_tvalid", 32'(m_tvalid), 32'd0);
                chk("drain_tready_sel", 32'(rs), 32'd1);
                chk("drain_tready_other", 32'(ro), 32'd0);
                if (sv && rst_n) begin
                    pop_beat(ms, b, ok);
                    if (ok) begin
                        chk("drain_src_last", 32'(sl), 32'(b.last));
                        if (b.last) begin
                            mb = 0;
                            md = 0;
                        end
                    end
                end
            end
            if (!rst_n) begin
                mb = 0; md = 0; ms = 0; ml = 1; mbeat = 0;
                e0 = '0; e1 = '0; et = '0;
            end
        end
    end

    // Phase sequencing: contention, random gaps/backpressure, alternating ready
    initial begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n  = 1'b1;
        gap_en = 1'b0;
        tready_mode = 0;
        start  = 1'b1;
        repeat (1500) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        gap_en = 1'b1;
        tready_mode = 1;
        repeat (2000) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        gap_en = 1'b0;
        tready_mode = 2;
        repeat (1500) begin
            @(posedge clk); #1;
        end
        stop = 1'b1;
        tready_mode = 0;
        for (int i = 0; i < 4000 && !(g_src[0].done && g_src[1].done); i++) begin
            @(posedge clk); #1;
        end
        if (!(g_src[0].done && g_src[1].done)) begin
            checks++; errors++;
            $display("FAIL finish_timeout: sources still active, required both done");
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("final_queue0_empty", 32'(g_src[0].q.size()), 32'd0);
        chk("final_queue1_empty", 32'(g_src[1].q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_rx_stream_arbiter.md
# eth_rx_stream_arbiter

Packet-granular, two-input round-robin AXI-Stream arbiter that shares a single `eth_pack_filter` instance between two Ethernet receive sources (e.g. two MAC RX streams, or a MAC and a loopback/test generator). It sits directly upstream of the filter's `s_axis_*` port. It locks a grant for a whole packet (until `tlast`) and enforces a maximum packet length by truncating and draining over-long packets. It exports grant state and per-source packet/truncation counters for status registers.

## Interface
- `STREAM_DATA_WIDTH`, 32: tdata width in bits (multiple of 8).
- `MAX_BEATS`, 400: maximum accepted beats per packet (1600 B at 32 bit); range 2..65535.
- `CNT_WIDTH`, 16: width of status counters.

- `clk_i`  in  1: single clock. Reset is synchronous and active-low.
- `s_rst_n_i`  in  1: synchronous active-low reset.
- `s0_axis_tdata_i` / `s1_axis_tdata_i`  in  STREAM_DATA_WIDTH: source data.
- `s0_axis_tkeep_i` / `s1_axis_tkeep_i`  in  STREAM_DATA_WIDTH/8: source byte enables.
- `s0_axis_tvalid_i` / `s1_axis_tvalid_i`  in  1: source valid.
- `s0_axis_tlast_i` / `s1_axis_tlast_i`  in  1: source end of packet.
- `s0_axis_tready_o` / `s1_axis_tready_o`  out  1: source ready.
- `m_axis_tdata_o`  out  STREAM_DATA_WIDTH: to filter `s_axis_tdata_i`.
- `m_axis_tkeep_o`  out  STREAM_DATA_WIDTH/8: to filter.
- `m_axis_tvalid_o`  out  1: to filter.
- `m_axis_tlast_o`  out  1: to filter; may be forced on truncation.
- `m_axis_tready_i`  in  1: from filter `s_axis_tready_o`.
- `grant_o`  out  2: one-hot current grant; 0 when idle.
- `busy_o`  out  1: state is BUSY or DRAIN.
- `pkt_cnt0_o` / `pkt_cnt1_o`  out  CNT_WIDTH: packets forwarded per source, wrapping.
- `trunc_cnt_o`  out  CNT_WIDTH: truncated packets (both sources), wrapping.

## Operation
- States: IDLE, BUSY, DRAIN. Registers: state, `sel` (1 bit), `last_sel`, `beat_cnt`, three counters.
- IDLE: both `tready` are 0, `m_axis_tvalid_o` is 0. If any `sN_tvalid` is 1, the arbiter picks a source. With one requester, it takes that one. With both, it takes `!last_sel`. Pick goes to `sel`/`last_sel`, `beat_cnt` clears to 0, next state is BUSY.
- BUSY: combinational pass-through of the selected source:
  - `m_axis_tdata/tkeep/tvalid` come from source `sel`.
  - `sN_tready_o` for `N==sel` equals `m_axis_tready_i`. The other source's tready is 0.
  - Beat accepted = `m_axis_tvalid_o & m_axis_tready_i`. Each accepted beat increments `beat_cnt`.
- Accepted beat with source `tlast`=1: `pkt_cnt[sel]` +1, next state is IDLE.
- Accepted beat with `tlast`=0 and `beat_cnt == MAX_BEATS-1`:
  - `m_axis_tlast_o` is forced 1 on that beat.
  - `pkt_cnt[sel]` +1 and `trunc_cnt` +1.
  - Next state is DRAIN.
- DRAIN: `m_axis_tvalid_o` is 0. Selected source tready is 1; the other source's is 0. Beats are discarded until an accepted (`valid & ready`) beat with `tlast`=1, then next state is IDLE.
- `grant_o` is `1<<sel` in BUSY/DRAIN and 0 in IDLE. `busy_o` is `state != IDLE`.
- Counters wrap from all-ones to 0. Source tvalid dropping mid-packet is legal; the arbiter waits, and the grant stays held.

## Timing
- Reset (`s_rst_n_i`=0 at a clk_i edge):
  - state IDLE, `last_sel`=1 (source 0 wins first tie), `sel`=0, `beat_cnt`=0, all counters 0.
  - All outputs therefore 0: every tready, `m_axis_tvalid_o`, `m_axis_tlast_o`, `grant_o`, `busy_o`; `m_axis_tdata/tkeep` are don't-care and driven 0 when idle.
- Reset mid-packet aborts immediately. The next packet restarts arbitration; the remainder of the aborted packet is treated as a new packet.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k gives BUSY, and the first beat can transfer in cycle k+1.
- Pass-through adds zero latency in BUSY; no tdata register.
- Inter-packet gap: at least 1 idle cycle per packet (the IDLE cycle), so peak throughput is N/(N+1) beats/cycle.
- Ties in IDLE alternate: packets alternate 0,1,0,1 under continuous contention. A lone requester may win consecutively.
- The `tlast` and truncation conditions coincide only when `tlast`=1; that is a normal end, with no truncation count.
- Packet of exactly MAX_BEATS beats ending with `tlast`: normal end, not truncated.
- Source tvalid is never inspected in IDLE for the non-chosen source beyond arbitration.

## Test plan
- Source 0 sends one 17-beat packet, filter tready=1 -> 17 beats on m_axis with tlast on beat 17, `grant_o`=2'b01 during transfer, `pkt_cnt0_o`=1, first beat out 1 cycle after s0 tvalid rises.
- Both sources continuously offer 4-beat packets for 8 packets -> output source order 0,1,0,1,0,1,0,1, no interleaving within a packet, `pkt_cnt0_o`=`pkt_cnt1_o`=4.
- Filter tready toggles 1,0,1,0 during a 10-beat s1 packet -> 10 beats delivered intact in order, s1 tready mirrors filter tready, s0 tready stays 0.
- MAX_BEATS=8, s0 sends 12 beats -> 8 beats out, beat 8 has tlast=1, the 4 remaining beats are consumed with m_axis_tvalid_o=0, `trunc_cnt_o`=1, the next s1 packet passes normally. An exactly 8-beat packet gives `trunc_cnt_o` unchanged.
- `s_rst_n_i` is pulsed low at beat 5 of a 20-beat packet -> the next edge shows all outputs 0 and counters 0; after release, source 0 wins the first tie.
- Preload `pkt_cnt1_o` to 16'hFFFF by sending 65535 packets (or force), then send 1 more -> wraps to 16'h0000.
